// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   Decode/execute stage of a three-stage RV32I pipeline. Holds the register
//   file, decodes R-type / I-type ALU, lw, sw and beq/bne, runs the ALU,
//   resolves branches, detects load-use hazards and registers the result
//   toward the MEM/WB stage.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   IFD_IR, IFD_NPC    instruction and its PC+4 from the fetch stage
//   wb_en/addr/data    register-file write port driven by MEM/WB
//   stall              combinational; fetch must hold IFD_IR for one cycle
//   condn_flag, adder  registered branch-taken redirect and its target
//   EX_*               registered result bundle for MEM/WB
//
// Fetch/decode protocol:
//   - While stall=1 the instruction on IFD_IR is not consumed; fetch presents
//     the same IFD_IR/IFD_NPC on the next cycle.
//   - While condn_flag=1 the instruction on IFD_IR is a wrong-path instruction
//     and is dropped; fetch uses adder as the next PC.
//   - The wb port carries the result EX produced one cycle earlier, so a
//     value is always visible through EX forward, WB bypass or the regfile.
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int NUM_REGS    = 32,
  parameter int INIT_SQUASH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IFD_IR,
  input  logic [31:0] IFD_NPC,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        condn_flag,
  output logic [31:0] adder,
  output logic        EX_Valid,
  output logic [31:0] EX_ALU_Out,
  output logic [31:0] EX_Store_Data,
  output logic [4:0]  EX_Rd,
  output logic        EX_Reg_Write,
  output logic        EX_Mem_Read,
  output logic        EX_Mem_Write
);

  localparam int SQ_W = (INIT_SQUASH < 1) ? 1 : $clog2(INIT_SQUASH + 1);
  localparam logic [SQ_W-1:0] SQ_INIT = SQ_W'(INIT_SQUASH);

  localparam logic [4:0] OPC_R   = 5'b01100;
  localparam logic [4:0] OPC_I   = 5'b00100;
  localparam logic [4:0] OPC_LW  = 5'b00000;
  localparam logic [4:0] OPC_SW  = 5'b01000;
  localparam logic [4:0] OPC_BR  = 5'b11000;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]     rf_q [NUM_REGS];
  logic [SQ_W-1:0] squash_q, squash_d;
  logic            condn_q, condn_d;
  logic [31:0]     adder_q, adder_d;
  logic            ex_valid_q, ex_valid_d;
  logic [31:0]     ex_alu_q, ex_alu_d;
  logic [31:0]     ex_store_q, ex_store_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            ex_rw_q, ex_rw_d;
  logic            ex_mr_q, ex_mr_d;
  logic            ex_mw_q, ex_mw_d;

  // ---------------------------------------------------------------------------
  // Field extraction and decode
  // ---------------------------------------------------------------------------
  logic [4:0]  opc, rs1, rs2, rd;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b;
  logic        is_r, is_i, is_lw, is_sw, is_br, supported;
  logic        uses_rs2, bubble, load_use;

  assign opc = IFD_IR[6:2];
  assign rd  = IFD_IR[11:7];
  assign f3  = IFD_IR[14:12];
  assign rs1 = IFD_IR[19:15];
  assign rs2 = IFD_IR[24:20];

  assign imm_i = {{20{IFD_IR[31]}}, IFD_IR[31:20]};
  assign imm_s = {{20{IFD_IR[31]}}, IFD_IR[31:25], IFD_IR[11:7]};
  assign imm_b = {{19{IFD_IR[31]}}, IFD_IR[31], IFD_IR[7], IFD_IR[30:25],
                  IFD_IR[11:8], 1'b0};

  always_comb begin
    // Only 32-bit encodings (IR[1:0]=11) are decoded.
    is_r  = (IFD_IR[1:0] == 2'b11) && (opc == OPC_R);
    is_i  = (IFD_IR[1:0] == 2'b11) && (opc == OPC_I);
    is_lw = (IFD_IR[1:0] == 2'b11) && (opc == OPC_LW) && (f3 == 3'b010);
    is_sw = (IFD_IR[1:0] == 2'b11) && (opc == OPC_SW) && (f3 == 3'b010);
    // beq (000) and bne (001) only
    is_br = (IFD_IR[1:0] == 2'b11) && (opc == OPC_BR) && (f3[2:1] == 2'b00);
    supported = is_r || is_i || is_lw || is_sw || is_br;
    uses_rs2  = is_r || is_sw || is_br;
  end

  // A wrong-path instruction (condn_flag high) or a start-up cycle is dropped
  // before any hazard or branch logic can see it.
  assign bubble = (squash_q != '0) || condn_q || !supported;

  always_comb begin
    load_use = 1'b0;
    if (!bubble && ex_valid_q && ex_mr_q && (ex_rd_q != 5'd0)) begin
      load_use = (rs1 == ex_rd_q) || (uses_rs2 && (rs2 == ex_rd_q));
    end
  end

  assign stall = load_use;

  // ---------------------------------------------------------------------------
  // Operand sourcing: EX forward beats WB bypass beats the register file.
  // A load in EX cannot forward; its data arrives on the wb port one cycle
  // later, which is what the load-use stall waits for.
  // ---------------------------------------------------------------------------
  logic        ex_fwd_ok;
  logic [31:0] rf_rs1, rf_rs2, op_a, op_b;

  assign ex_fwd_ok = ex_valid_q && ex_rw_q && !ex_mr_q;

  always_comb begin
    rf_rs1 = '0;
    rf_rs2 = '0;
    if (int'(rs1) < NUM_REGS) rf_rs1 = rf_q[rs1];
    if (int'(rs2) < NUM_REGS) rf_rs2 = rf_q[rs2];
  end

  always_comb begin
    op_a = rf_rs1;
    if (rs1 == 5'd0)                          op_a = '0;
    else if (ex_fwd_ok && (ex_rd_q == rs1))   op_a = ex_alu_q;
    else if (wb_en && (wb_addr == rs1))       op_a = wb_data;
  end

  always_comb begin
    op_b = rf_rs2;
    if (rs2 == 5'd0)                          op_b = '0;
    else if (ex_fwd_ok && (ex_rd_q == rs2))   op_b = ex_alu_q;
    else if (wb_en && (wb_addr == rs2))       op_b = wb_data;
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] alu_b, alu_res, br_target, result;
  logic [4:0]  shamt;
  logic        alt, taken;

  assign alu_b = is_r ? op_b : imm_i;
  assign shamt = alu_b[4:0];
  // IR[30] selects sub/sra for R-type; for I-type only srai uses it (addi
  // never subtracts even when its immediate has bit 10 set).
  assign alt   = is_r ? IFD_IR[30] : ((f3 == 3'b101) && IFD_IR[30]);

  always_comb begin
    alu_res = '0;
    case (f3)
      3'b000:  alu_res = alt ? (op_a - alu_b) : (op_a + alu_b);
      3'b001:  alu_res = op_a << shamt;
      3'b010:  alu_res = {31'd0, ($signed(op_a) < $signed(alu_b))};
      3'b011:  alu_res = {31'd0, (op_a < alu_b)};
      3'b100:  alu_res = op_a ^ alu_b;
      3'b101: begin
        // Kept as separate assignments so the arithmetic shift stays signed.
        if (alt) alu_res = $unsigned($signed(op_a) >>> shamt);
        else     alu_res = op_a >> shamt;
      end
      3'b110:  alu_res = op_a | alu_b;
      default: alu_res = op_a & alu_b;
    endcase
  end

  assign br_target = IFD_NPC - 32'd4 + imm_b;
  assign taken     = is_br && (f3[0] ? (op_a != op_b) : (op_a == op_b));

  always_comb begin
    result = alu_res;
    if (is_lw)      result = op_a + imm_i;
    else if (is_sw) result = op_a + imm_s;
    else if (is_br) result = br_target;
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    squash_d   = (squash_q != '0) ? (squash_q - 1'b1) : squash_q;
    condn_d    = 1'b0;
    adder_d    = adder_q;
    ex_valid_d = 1'b0;
    ex_alu_d   = '0;
    ex_store_d = '0;
    ex_rd_d    = '0;
    ex_rw_d    = 1'b0;
    ex_mr_d    = 1'b0;
    ex_mw_d    = 1'b0;
    if (!bubble && !load_use) begin
      ex_valid_d = 1'b1;
      ex_alu_d   = result;
      ex_rw_d    = is_r || is_i || is_lw;
      ex_rd_d    = (is_r || is_i || is_lw) ? rd : 5'd0;
      ex_mr_d    = is_lw;
      ex_mw_d    = is_sw;
      ex_store_d = is_sw ? op_b : 32'd0;
      if (taken) begin
        condn_d = 1'b1;
        adder_d = br_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      squash_q   <= SQ_INIT;
      condn_q    <= 1'b0;
      adder_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_alu_q   <= '0;
      ex_store_q <= '0;
      ex_rd_q    <= '0;
      ex_rw_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      ex_mw_q    <= 1'b0;
    end else begin
      squash_q   <= squash_d;
      condn_q    <= condn_d;
      adder_q    <= adder_d;
      ex_valid_q <= ex_valid_d;
      ex_alu_q   <= ex_alu_d;
      ex_store_q <= ex_store_d;
      ex_rd_q    <= ex_rd_d;
      ex_rw_q    <= ex_rw_d;
      ex_mr_q    <= ex_mr_d;
      ex_mw_q    <= ex_mw_d;
    end
  end

  // Register file; x0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0) && (int'(wb_addr) < NUM_REGS)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign condn_flag    = condn_q;
  assign adder         = adder_q;
  assign EX_Valid      = ex_valid_q;
  assign EX_ALU_Out    = ex_alu_q;
  assign EX_Store_Data = ex_store_q;
  assign EX_Rd         = ex_rd_q;
  assign EX_Reg_Write  = ex_rw_q;
  assign EX_Mem_Read   = ex_mr_q;
  assign EX_Mem_Write  = ex_mw_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed and randomized checks of id_ex_stage. The bench plays the fetch
//   and MEM/WB stages. Expected values come from an architectural model: a
//   register array updated in program order, a data memory and the stall /
//   squash rules, with no knowledge of how the DUT forwards.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int INIT_SQUASH = 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IFD_IR = '0, IFD_NPC = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        stall, condn_flag, EX_Valid, EX_Reg_Write, EX_Mem_Read, EX_Mem_Write;
  logic [31:0] adder, EX_ALU_Out, EX_Store_Data;
  logic [4:0]  EX_Rd;

  always #5 clk = ~clk;

  id_ex_stage #(.NUM_REGS(32), .INIT_SQUASH(INIT_SQUASH)) dut (
    .clk(clk), .rst_n(rst_n), .IFD_IR(IFD_IR), .IFD_NPC(IFD_NPC),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .condn_flag(condn_flag), .adder(adder),
    .EX_Valid(EX_Valid), .EX_ALU_Out(EX_ALU_Out), .EX_Store_Data(EX_Store_Data),
    .EX_Rd(EX_Rd), .EX_Reg_Write(EX_Reg_Write), .EX_Mem_Read(EX_Mem_Read),
    .EX_Mem_Write(EX_Mem_Write)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_rf [32];
  logic [31:0] dmem [logic [31:0]];
  int          squash_left;
  // what EX should hold now (e_*) and what it held one cycle ago (m_*)
  logic        e_valid, e_rw, e_mr, e_mw, e_cf;
  logic [4:0]  e_rd;
  logic [31:0] e_alu, e_st, e_adder, e_wbd;
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_wbd;
  logic        obs_stall;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    squash_left = INIT_SQUASH;
    e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_cf = 0;
    e_rd = '0; e_alu = '0; e_st = '0; e_adder = '0; e_wbd = '0;
    m_valid = 0; m_rw = 0; m_rd = '0; m_wbd = '0;
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] a);
    if (dmem.exists(a)) return dmem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] arith(input logic [2:0] f3, input bit alt,
                                        input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx;
    logic [4:0] s;
    sx = x;
    s  = y[4:0];
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << s;
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: begin
        if (alt) return sx >>> s;
        return x >> s;
      end
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [4:0] rd);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // ---------------- driver: one decode cycle ----------------
  // Called at posedge+1; returns at the next posedge+1 with all checks done.
  task automatic cycle(input logic [31:0] ir, input logic [31:0] pc, output bit stalled);
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] a, b, immi, imms, immb, res, tgt;
    bit is_r, is_i, is_lw, is_sw, is_br, sup, bub, use2, st, taken;
    rd = ir[11:7]; f3 = ir[14:12]; rs1 = ir[19:15]; rs2 = ir[24:20];
    IFD_IR  = ir;
    IFD_NPC = pc + 32'd4;
    wb_en   = m_valid && m_rw;
    wb_addr = m_rd;
    wb_data = m_wbd;

    is_r  = (ir[6:0] == 7'b0110011);
    is_i  = (ir[6:0] == 7'b0010011);
    is_lw = (ir[6:0] == 7'b0000011) && (f3 == 3'b010);
    is_sw = (ir[6:0] == 7'b0100011) && (f3 == 3'b010);
    is_br = (ir[6:0] == 7'b1100011) && (f3 == 3'b000 || f3 == 3'b001);
    sup   = is_r || is_i || is_lw || is_sw || is_br;
    bub   = (squash_left > 0) || e_cf || !sup;
    use2  = is_r || is_sw || is_br;
    st    = !bub && e_valid && e_mr && (e_rd != 0) &&
            ((rs1 == e_rd) || (use2 && rs2 == e_rd));

    a = ref_rf[rs1];
    b = ref_rf[rs2];
    immi = {{20{ir[31]}}, ir[31:20]};
    imms = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    immb = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    tgt  = pc + immb;
    if (is_r)       res = arith(f3, ir[30], a, b);
    else if (is_i)  res = arith(f3, (f3 == 3'b101) && ir[30], a, immi);
    else if (is_lw) res = a + immi;
    else if (is_sw) res = a + imms;
    else            res = tgt;
    taken = is_br && (f3[0] ? (a != b) : (a == b));

    @(negedge clk);
    obs_stall = stall;
    chk("stall", {31'd0, stall}, {31'd0, st});
    @(posedge clk);
    #1;

    m_valid = e_valid; m_rw = e_rw; m_rd = e_rd; m_wbd = e_wbd;
    if (squash_left > 0) squash_left--;
    if (bub || st) begin
      e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_cf = 0;
      e_rd = '0; e_alu = '0; e_st = '0; e_wbd = '0;
    end else begin
      e_valid = 1;
      e_rw    = is_r || is_i || is_lw;
      e_rd    = e_rw ? rd : 5'd0;
      e_mr    = is_lw;
      e_mw    = is_sw;
      e_alu   = res;
      e_st    = is_sw ? b : 32'd0;
      e_cf    = taken;
      if (taken) e_adder = tgt;
      e_wbd   = is_lw ? load_val(res) : res;
      if (e_rw && rd != 0) ref_rf[rd] = e_wbd;
      if (is_sw) dmem[res] = b;
    end

    chk("ex_valid",  {31'd0, EX_Valid},     {31'd0, e_valid});
    chk("ex_alu",    EX_ALU_Out,            e_alu);
    chk("ex_store",  EX_Store_Data,         e_st);
    chk("ex_rd",     {27'd0, EX_Rd},        {27'd0, e_rd});
    chk("ex_rw",     {31'd0, EX_Reg_Write}, {31'd0, e_rw});
    chk("ex_mr",     {31'd0, EX_Mem_Read},  {31'd0, e_mr});
    chk("ex_mw",     {31'd0, EX_Mem_Write}, {31'd0, e_mw});
    chk("condn",     {31'd0, condn_flag},   {31'd0, e_cf});
    if (e_cf) chk("adder", adder, e_adder);
    stalled = st;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] pc);
    bit st;
    for (int t = 0; t < 3; t++) begin
      cycle(ir, pc, st);
      if (!st) break;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, EX_Valid},     32'd0);
    chk({tag, "_alu"},   EX_ALU_Out,            32'd0);
    chk({tag, "_st"},    EX_Store_Data,         32'd0);
    chk({tag, "_rd"},    {27'd0, EX_Rd},        32'd0);
    chk({tag, "_ctl"},   {29'd0, EX_Reg_Write, EX_Mem_Read, EX_Mem_Write}, 32'd0);
    chk({tag, "_condn"}, {31'd0, condn_flag},   32'd0);
    chk({tag, "_adder"}, adder,                 32'd0);
    chk({tag, "_stall"}, {31'd0, stall},        32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [12:0] bo;
    int k;
    rd  = 5'($urandom_range(0, 5));
    rs1 = 5'($urandom_range(0, 5));
    rs2 = 5'($urandom_range(0, 5));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom_range(0, 4095));
    bo  = 13'($urandom_range(0, 8191)) & 13'h1FFE;
    k   = $urandom_range(0, 9);
    case (k)
      0, 1, 2: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ?
                            7'h20 : 7'h00, rs2, rs1, f3, rd);
      3, 4: begin
        if (f3 == 3'd1)      imm = {7'h00, imm[4:0]};
        else if (f3 == 3'd5) imm = {1'b0, imm[10], 5'd0, imm[4:0]};
        return enc_i(imm, rs1, f3, rd);
      end
      5: return enc_lw({imm[11:2], 2'b00}, rs1, rd);
      6: return enc_sw({imm[11:2], 2'b00}, rs2, rs1);
      7, 8: return enc_b(bo, rs2, rs1, 3'($urandom_range(0, 1)));
      default: return {imm, 8'h12, rd, 7'b0110111};  // lui: not decoded here
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit st;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // start-up squash, then add x1,x2,x7 = 5+3
    issue(enc_r(7'h00, 5'd7, 5'd2, 3'd0, 5'd1), 32'd0);
    chk("squash_valid", {31'd0, EX_Valid}, 32'd0);
    issue(enc_i(12'd5, 5'd0, 3'd0, 5'd2), 32'd4);
    issue(enc_i(12'd3, 5'd0, 3'd0, 5'd7), 32'd8);
    issue(enc_r(7'h00, 5'd7, 5'd2, 3'd0, 5'd1), 32'd12);
    chk("add_8", EX_ALU_Out, 32'd8);
    chk("add_rd", {27'd0, EX_Rd}, 32'd1);
    chk("add_rw", {31'd0, EX_Reg_Write}, 32'd1);
    cycle(enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd3), 32'd16, st);
    chk("fwd_13", EX_ALU_Out, 32'd13);
    chk("fwd_nostall", {31'd0, obs_stall}, 32'd0);

    // addi with negative immediate, then lw address
    issue(enc_i(12'd10, 5'd0, 3'd0, 5'd4), 32'd20);
    issue(enc_i(12'hFCE, 5'd4, 3'd0, 5'd15), 32'd24);
    chk("addi_neg", EX_ALU_Out, 32'hFFFF_FFD8);
    issue(enc_i(12'h100, 5'd0, 3'd0, 5'd9), 32'd28);
    dmem[32'h108] = 32'h0000_CAFE;
    issue(enc_lw(12'd8, 5'd9, 5'd14), 32'd32);
    chk("lw_addr", EX_ALU_Out, 32'h108);
    chk("lw_mr", {31'd0, EX_Mem_Read}, 32'd1);

    // load-use into sw: one stall cycle, then bypass supplies 0xCAFE
    cycle(enc_sw(12'd8, 5'd14, 5'd8), 32'd36, st);
    chk("lu_stall", {31'd0, obs_stall}, 32'd1);
    chk("lu_bubble", {31'd0, EX_Valid}, 32'd0);
    cycle(enc_sw(12'd8, 5'd14, 5'd8), 32'd36, st);
    chk("lu_release", {31'd0, obs_stall}, 32'd0);
    chk("sw_data", EX_Store_Data, 32'h0000_CAFE);
    chk("sw_addr", EX_ALU_Out, 32'd8);

    // beq taken at PC=20, then squashed slti; then not-taken beq
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd17), 32'd40);
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd18), 32'd44);
    issue(enc_b(13'd8, 5'd18, 5'd17, 3'd0), 32'd20);
    chk("beq_taken", {31'd0, condn_flag}, 32'd1);
    chk("beq_adder", adder, 32'd28);
    chk("beq_rw", {31'd0, EX_Reg_Write}, 32'd0);
    issue(enc_i(12'd3, 5'd1, 3'd2, 5'd5), 32'd24);
    chk("beq_squash", {31'd0, EX_Valid}, 32'd0);
    chk("beq_1cyc", {31'd0, condn_flag}, 32'd0);
    issue(enc_i(12'd9, 5'd0, 3'd0, 5'd18), 32'd28);
    issue(enc_b(13'd8, 5'd18, 5'd17, 3'd0), 32'd20);
    chk("beq_nt", {31'd0, condn_flag}, 32'd0);
    chk("beq_nt_valid", {31'd0, EX_Valid}, 32'd1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      issue(rand_instr(), 32'($urandom_range(0, 1023)) << 2);
    end

    // reset while condn_flag is high
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd17), 32'd100);
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd18), 32'd104);
    issue(enc_b(13'd8, 5'd18, 5'd17, 3'd0), 32'd108);
    chk("pre_rst_taken", {31'd0, condn_flag}, 32'd1);
    #2;
    rst_n = 1'b0;
    wb_en = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    issue(enc_r(7'h00, 5'd18, 5'd17, 3'd0, 5'd1), 32'd0);
    chk("rst_squash", {31'd0, EX_Valid}, 32'd0);
    issue(enc_r(7'h00, 5'd18, 5'd17, 3'd0, 5'd1), 32'd4);
    chk("rst_rf_zero", EX_ALU_Out, 32'd0);
    chk("rst_rf_valid", {31'd0, EX_Valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
